// File: rtl/uart_pkg.sv
// Shared 8N1 UART definitions.
// Used by both the receiver and the transmitter side of the link.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } uart_state_e;

  // Clock count at which the start bit is re-checked.
  function automatic int half_bit(input int clks);
    return (clks - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Single-clock first-word-fall-through byte FIFO.
// Pointers carry one extra wrap bit to tell full from empty.
module uart_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        do_wr;
  logic        do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  // A pop in the same cycle frees the slot the push lands in.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | rd_en);
  assign drop  = wr_en & full & ~rd_en;

  assign rd_data = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver feeding a FWFT byte FIFO.
// Frame errors pulse once; dropped bytes raise a sticky overrun.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 3,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          rxd,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          clear_overrun,
  output logic                          busy
);

  localparam int CW = 16;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(half_bit(CLKS_PER_BIT));
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

  uart_state_e   state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          push_q, push_d;
  logic          fe_q, fe_d;
  logic          overrun_q;
  logic          rxd_meta, rxd_s;
  logic          fifo_empty;
  logic          fifo_drop;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      push_q    <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      push_q    <= push_d;
      fe_q      <= fe_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    push_d    = 1'b0;
    fe_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rxd_s) begin
          state_d   = START;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end
      START: begin
        if (clk_cnt_q == HALF) begin
          clk_cnt_d = '0;
          state_d   = rxd_s ? IDLE : DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (clk_cnt_q == LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rxd_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) state_d = STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (clk_cnt_q == LAST) begin
          clk_cnt_d = '0;
          if (rxd_s) begin
            push_d  = 1'b1;
            state_d = IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rxd_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // shift_q is untouched in IDLE, so it still holds the byte here.
  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (push_q),
    .wr_data (shift_q),
    .rd_en   (m_ready),
    .rd_data (m_data),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .drop    (fifo_drop)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)          overrun_q <= 1'b0;
    else if (fifo_drop)    overrun_q <= 1'b1;
    else if (clear_overrun) overrun_q <= 1'b0;
  end

  assign m_valid   = ~fifo_empty;
  assign frame_err = fe_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered with a byte scoreboard.
// Runs with CLKS_PER_BIT=3 and FIFO_DEPTH=4.
module tb_uart_rx_buffered;

  localparam int CPB   = 3;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       rxd;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [2:0] fifo_count;
  logic       frame_err;
  logic       overrun;
  logic       clear_overrun;
  logic       busy;

  int n_pass  = 0;
  int n_total = 0;
  int fe_cnt  = 0;
  int fe0;
  logic exp_ovr;
  logic [7:0] exp_q [$];

  uart_rx_buffered #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .rxd           (rxd),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .fifo_count    (fifo_count),
    .frame_err     (frame_err),
    .overrun       (overrun),
    .clear_overrun (clear_overrun),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic model_push(input logic [7:0] b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else exp_ovr = 1'b1;
  endtask

  task automatic read_one(input string tag);
    logic [8:0] e;
    int w;
    w = 0;
    while (m_valid !== 1'b1 && w < 100) begin
      tick(1);
      w++;
    end
    chk({tag, "_valid"}, 32'(m_valid), 32'd1);
    e = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
    chk(tag, 32'({1'b0, m_data}), 32'(e));
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
  endtask

  initial begin
    reset_n       = 1'b0;
    rxd           = 1'b1;
    m_ready       = 1'b0;
    clear_overrun = 1'b0;
    exp_ovr       = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(4);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fe", 32'(frame_err), 32'd0);

    // good frame: m_valid rises two cycles after the stop sample
    fe0 = fe_cnt;
    send_frame(8'hA5, 1'b1);
    rxd = 1'b1;
    model_push(8'hA5);
    tick(2);
    chk("a5_early", 32'(m_valid), 32'd0);
    tick(1);
    chk("a5_rise", 32'(m_valid), 32'd1);
    chk("a5_count", 32'(fifo_count), 32'd1);
    read_one("a5");
    chk("a5_fe", 32'(fe_cnt - fe0), 32'd0);
    chk("a5_empty", 32'(m_valid), 32'd0);

    // bad stop bit followed by a held break
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    tick(40);
    chk("brk_busy", 32'(busy), 32'd1);
    chk("brk_fe1", 32'(fe_cnt - fe0), 32'd1);
    rxd = 1'b1;
    tick(4);
    chk("brk_idle", 32'(busy), 32'd0);
    chk("brk_fe", 32'(fe_cnt - fe0), 32'd1);
    chk("brk_count", 32'(fifo_count), 32'd0);

    // one-cycle glitch
    fe0 = fe_cnt;
    rxd = 1'b0;
    tick(1);
    rxd = 1'b1;
    tick(3);
    chk("gl_start", 32'(busy), 32'd1);
    tick(1);
    chk("gl_idle", 32'(busy), 32'd0);
    tick(4);
    chk("gl_fe", 32'(fe_cnt - fe0), 32'd0);
    chk("gl_count", 32'(fifo_count), 32'd0);

    // overflow with stalled consumer
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1);
      rxd = 1'b1;
      model_push(8'(i));
    end
    tick(4);
    chk("ov_count", 32'(fifo_count), 32'd4);
    chk("ov_flag", 32'(overrun), 32'(exp_ovr));
    for (int i = 0; i < 4; i++) read_one("ov_rd");
    chk("ov_drain", 32'(fifo_count), 32'd0);
    chk("ov_sticky", 32'(overrun), 32'd1);
    clear_overrun = 1'b1;
    tick(1);
    clear_overrun = 1'b0;
    exp_ovr = 1'b0;
    chk("ov_clear", 32'(overrun), 32'(exp_ovr));

    // push into a full FIFO with a simultaneous pop
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i), 1'b1);
      rxd = 1'b1;
      model_push(8'(i));
    end
    send_frame(8'h05, 1'b1);
    rxd = 1'b1;
    tick(2);
    chk("sim_full", 32'(fifo_count), 32'd4);
    chk("sim_head", 32'(m_data), 32'(exp_q.pop_front()));
    exp_q.push_back(8'h05);
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
    chk("sim_count", 32'(fifo_count), 32'd4);
    chk("sim_ovr", 32'(overrun), 32'd0);
    for (int i = 0; i < 4; i++) read_one("sim_rd");

    // reset during bit 4 of 0xFF
    fe0 = fe_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rxd = 1'b1;
    tick(1);
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(3);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_valid", 32'(m_valid), 32'd0);
    tick(40);
    chk("mr_count", 32'(fifo_count), 32'd0);
    chk("mr_fe", 32'(fe_cnt - fe0), 32'd0);
    send_frame(8'h55, 1'b1);
    rxd = 1'b1;
    model_push(8'h55);
    tick(4);
    read_one("mr_55");
    chk("sb_left", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_rx_buffered.md
UART_RX_BUFFERED -- requirements
Module: uart_rx_buffered

Interface
REQ-001 Parameter CLKS_PER_BIT, default 3, clock cycles per serial bit; legal range 3..65535.
REQ-002 Parameter FIFO_DEPTH, default 16, receive byte FIFO depth; power of two, 2..256.
REQ-003 clock  input  1  single clock for all logic; all logic on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 rxd  input  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-006 m_data  output  8  head-of-FIFO byte; valid only while m_valid=1.
REQ-007 m_valid  output  1  FIFO non-empty.
REQ-008 m_ready  input  1  consumer accept; pop when m_valid & m_ready.
REQ-009 fifo_count  output  clog2(FIFO_DEPTH)+1  bytes currently stored.
REQ-010 frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-011 overrun  output  1  sticky; a good byte was dropped because the FIFO was full.
REQ-012 clear_overrun  input  1  synchronous clear of overrun.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 rxd SHALL pass through a 2-flop synchronizer, rxd_s; all decisions use rxd_s.
REQ-015 The FSM SHALL have states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-016 IDLE: when rxd_s=0, go to START, clear bit counter and clock counter.
REQ-017 START: at clock count (CLKS_PER_BIT-1)/2, sample rxd_s; 0 -> DATA with counter reload; 1 -> IDLE as a glitch, with no output.
REQ-018 DATA: sample every CLKS_PER_BIT cycles after the start mid-sample; shift LSB-first; after the 8th sample go to STOP.
REQ-019 STOP: sample CLKS_PER_BIT cycles after bit 7; 1 -> push byte, go to IDLE in the next cycle; 0 -> pulse frame_err, discard byte, go to WAIT_HIGH.
REQ-020 WAIT_HIGH: remain until rxd_s=1, then go to IDLE; break conditions produce exactly one frame_err.
REQ-021 Push occurs in the cycle after the stop sample; m_valid SHALL rise in the following cycle when the FIFO was empty.
REQ-022 The FIFO SHALL be first-word-fall-through: m_data is stable and valid whenever m_valid=1, and changes only after a pop.
REQ-023 On push with the FIFO full and no simultaneous pop: drop the byte, set overrun, and leave FIFO contents unchanged.
REQ-024 On push with the FIFO full and a simultaneous pop: accept both, and fifo_count stays at FIFO_DEPTH.
REQ-025 On simultaneous push and pop at any count: fifo_count unchanged, and byte order preserved.
REQ-026 m_ready while m_valid=0 SHALL be ignored; fifo_count never underflows.
REQ-027 Read and write pointers SHALL be clog2(FIFO_DEPTH)+1 bits wide, wrapping naturally; full/empty are derived from the MSB compare.
REQ-028 When clear_overrun and a new overrun occur in the same cycle, the set SHALL win.
REQ-029 The receiver SHALL continue receiving regardless of FIFO state and consumer stalls.

Reset
REQ-030 Reset SHALL force: state=IDLE, counters=0, synchronizer flops=1, FIFO empty, m_valid=0, m_data=0, fifo_count=0, frame_err=0, overrun=0, busy=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame without a push or frame_err.
REQ-032 After reset release, a line held low SHALL be treated as a start edge.

Structure
REQ-033 UART_STATE enum encodings and the 8N1 frame constants (DATA_BITS=8, STOP_BITS=1) SHALL live in the shared uart package used by the transmitter.
REQ-034 The FIFO SHALL be one sub-module, uart_byte_fifo (parameter DEPTH, FWFT, synchronous single clock); the FSM stays in the top.
REQ-035 The FIFO SHALL use no vendor IP, so both ends of the link simulate identically.

Verification
REQ-036 CLKS_PER_BIT=3: send 0xA5 with stop=1 -> one push; m_data=0xA5; m_valid high 2 cycles after the stop mid-sample; frame_err=0.
REQ-037 Send 0x3C with stop=0, then hold the line low for 40 cycles -> a single frame_err pulse, no push, and busy until rxd returns high.
REQ-038 Send a 1-cycle low glitch on idle rxd -> no push, no frame_err, and FSM back in IDLE within 3 cycles.
REQ-039 FIFO_DEPTH=4, m_ready=0: send 0x01..0x05 -> fifo_count=4, overrun=1, and reads return 0x01..0x04; clear_overrun -> overrun=0.
REQ-040 FIFO full, with m_ready=1 held during the 5th stop sample -> no overrun, count stays 4, and order 0x01..0x05 is preserved.
REQ-041 Assert reset_n low during bit 4 of 0xFF -> no push; next frame 0x55 received correctly.
